// File: rtl/core_types_pkg.sv
// Shared types and constants for the load/store path: FSM states, fault codes,
// RV32I size/sign encodings and the legality/alignment helpers used at issue.
package core_types_pkg;

   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } mau_state_t;

   localparam logic [1:0] FAULT_MISALIGN = 2'b01;
   localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;
   localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Loads accept the five RV32I load encodings; stores only B/H/W.
   function automatic logic is_illegal(input logic       rmem,
                                       input logic       wmem,
                                       input logic [2:0] f3);
      logic bad;
      bad = 1'b0;
      if (rmem && wmem)
         bad = 1'b1;
      else if (rmem)
         bad = !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU));
      else
         bad = (f3 > F3_W);
      return bad;
   endfunction

   function automatic logic is_misaligned(input logic [2:0] f3,
                                          input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      case (f3[1:0])
         2'b01:   mis = off[0];
         2'b10:   mis = (off != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering: store byte enables and replicated write data, and
// load lane extraction with sign or zero extension. Purely combinational.
module lsu_byte_lane
   import core_types_pkg::*;
(
   input  logic [1:0]        st_size,
   input  logic [1:0]        st_off,
   input  logic [DATA_W-1:0] st_data,
   output logic [3:0]        st_be,
   output logic [DATA_W-1:0] st_wdata,
   input  logic [2:0]        ld_funct3,
   input  logic [1:0]        ld_off,
   input  logic [DATA_W-1:0] ld_rdata,
   output logic [DATA_W-1:0] ld_data
);

   logic signed [7:0]        ld_byte_s;
   logic signed [15:0]       ld_half_s;
   logic signed [DATA_W-1:0] ld_byte_ext;
   logic signed [DATA_W-1:0] ld_half_ext;

   always_comb begin
      st_be    = 4'b1111;
      st_wdata = st_data;
      case (st_size)
         2'b00: begin
            st_be    = 4'b0001 << st_off;
            st_wdata = {4{st_data[7:0]}};
         end
         2'b01: begin
            st_be    = 4'b0011 << st_off;
            st_wdata = {2{st_data[15:0]}};
         end
         default: begin
            st_be    = 4'b1111;
            st_wdata = st_data;
         end
      endcase
   end

   // Halfword loads are aligned, so only the upper offset bit picks the lane.
   always_comb begin
      ld_byte_s   = signed'(ld_rdata[{ld_off, 3'b000} +: 8]);
      ld_half_s   = signed'(ld_rdata[{ld_off[1], 4'b0000} +: 16]);
      ld_byte_ext = ld_byte_s;
      ld_half_ext = ld_half_s;
      case (ld_funct3)
         F3_B:    ld_data = ld_byte_ext;
         F3_H:    ld_data = ld_half_ext;
         F3_BU:   ld_data = {24'd0, ld_byte_s};
         F3_HU:   ld_data = {16'd0, ld_half_s};
         default: ld_data = ld_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one req/ack bus transaction per load or store, stalling
// the pipeline until the transaction completes, faults or times out.
module mem_access_unit
   import core_types_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic        Clock,
   input  logic        nReset,
   input  logic        ex_valid,
   input  logic        Rmem,
   input  logic        Wmem,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   output logic [31:0] memOut,
   output logic        stall,
   output logic        access_fault,
   output logic [1:0]  fault_cause
);

   localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

   mau_state_t  state;
   logic [7:0]  wait_cnt;
   logic [2:0]  funct3_p1;
   logic [1:0]  off_p1;

   logic        start;
   logic        illegal;
   logic        misalign;
   logic        start_ok;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [31:0] ld_data;

   assign start    = ex_valid & (Rmem | Wmem);
   assign illegal  = is_illegal(Rmem, Wmem, funct3);
   assign misalign = is_misaligned(funct3, addr[1:0]);
   assign start_ok = start & ~illegal & ~misalign;

   // The issuing cycle stalls combinationally so EX holds while the bus runs.
   assign stall = ((state == IDLE) && start_ok) || (state == ACCESS);

   lsu_byte_lane u_lane (
      .st_size   (funct3[1:0]),
      .st_off    (addr[1:0]),
      .st_data   (wdata),
      .st_be     (st_be),
      .st_wdata  (st_wdata),
      .ld_funct3 (funct3_p1),
      .ld_off    (off_p1),
      .ld_rdata  (bus_rdata),
      .ld_data   (ld_data)
   );

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         funct3_p1    <= '0;
         off_p1       <= '0;
         bus_req      <= 1'b0;
         bus_we       <= 1'b0;
         bus_addr     <= '0;
         bus_be       <= '0;
         bus_wdata    <= '0;
         memOut       <= '0;
         access_fault <= 1'b0;
         fault_cause  <= '0;
      end else begin
         access_fault <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (illegal) begin
                     access_fault <= 1'b1;
                     fault_cause  <= FAULT_ILLEGAL;
                  end else if (misalign) begin
                     access_fault <= 1'b1;
                     fault_cause  <= FAULT_MISALIGN;
                  end else begin
                     bus_we    <= Wmem;
                     bus_addr  <= {addr[31:2], 2'b00};
                     bus_be    <= st_be;
                     bus_wdata <= st_wdata;
                     funct3_p1 <= funct3;
                     off_p1    <= addr[1:0];
                     wait_cnt  <= '0;
                     bus_req   <= 1'b1;
                     state     <= ACCESS;
                  end
               end
            end
            // ---- bus phase: ack has priority over the timeout on the same cycle
            ACCESS: begin
               wait_cnt <= wait_cnt + 8'd1;
               if (bus_ack) begin
                  bus_req <= 1'b0;
                  if (!bus_we)
                     memOut <= ld_data;
                  state <= DONE;
               end else if (wait_cnt == LAST_WAIT) begin
                  bus_req      <= 1'b0;
                  memOut       <= '0;
                  access_fault <= 1'b1;
                  fault_cause  <= FAULT_TIMEOUT;
                  state        <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               bus_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
